// File: rtl/gf_fac_pkg.sv
// Shared definitions for the 4-bit shared-factor word: field positions,
// widths, check-vector layout, FSM encoding and the recovered-nibble payload.
package gf_fac_pkg;

  localparam int unsigned FAC_W = 9;
  localparam int unsigned NIB_W = 4;

  // Field positions inside the 9-bit factor word
  localparam int unsigned AA_BIT = 8;
  localparam int unsigned SA_MSB = 7;
  localparam int unsigned SA_LSB = 6;
  localparam int unsigned AH_BIT = 5;
  localparam int unsigned HI_MSB = 4;
  localparam int unsigned HI_LSB = 3;
  localparam int unsigned AL_BIT = 2;
  localparam int unsigned LO_MSB = 1;
  localparam int unsigned LO_LSB = 0;

  // Per-check error vector layout
  localparam int unsigned CHK_W  = 4;
  localparam int unsigned CHK_SA = 0;
  localparam int unsigned CHK_AH = 1;
  localparam int unsigned CHK_AL = 2;
  localparam int unsigned CHK_AA = 3;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic             err;
    logic [NIB_W-1:0] nib;
  } nib_word_t;

endpackage

// File: rtl/fac_4_check.sv
// Combinational consistency checker for one factor word: recovers the nibble
// and reports which redundant sums disagree with it.
module fac_4_check
  import gf_fac_pkg::*;
(
  input  logic [FAC_W-1:0] fac,
  output logic [NIB_W-1:0] nib_c,
  output logic [CHK_W-1:0] chk_c
);

  logic [1:0] hi;
  logic [1:0] lo;
  logic [1:0] sa;

  assign hi = fac[HI_MSB:HI_LSB];
  assign lo = fac[LO_MSB:LO_LSB];
  assign sa = fac[SA_MSB:SA_LSB];

  always_comb begin
    chk_c         = '0;
    chk_c[CHK_SA] = sa != (hi ^ lo);
    chk_c[CHK_AH] = fac[AH_BIT] != (hi[1] ^ hi[0]);
    chk_c[CHK_AL] = fac[AL_BIT] != (lo[1] ^ lo[0]);
    chk_c[CHK_AA] = fac[AA_BIT] != (sa[1] ^ sa[0]);
  end

  assign nib_c = {hi, lo};

endmodule

// File: rtl/unfac_4_stream.sv
// Streaming factor-word checker: recovers nibbles with an error flag through an
// output register plus one skid entry, tracks error status and optionally halts.
module unfac_4_stream
  import gf_fac_pkg::*;
#(
  parameter int unsigned ERR_CNT_W   = 8,
  parameter bit          HALT_ON_ERR = 1'b0
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FAC_W-1:0]     in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NIB_W-1:0]     out_a,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic                 sticky_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 halted
);

  logic [NIB_W-1:0] chk_nib;
  logic [CHK_W-1:0] chk_vec;
  nib_word_t        in_word;
  logic             accept;

  fac_4_check u_check (
    .fac   (in_q),
    .nib_c (chk_nib),
    .chk_c (chk_vec)
  );

  assign in_word = '{err: |chk_vec, nib: chk_nib};
  assign accept  = in_valid && in_ready;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  nib_word_t            out_word;
  nib_word_t            out_word_nxt;
  nib_word_t            skid_word;
  nib_word_t            skid_word_nxt;
  logic                 skid_valid;
  logic                 skid_valid_nxt;
  logic                 out_valid_nxt;
  logic                 in_ready_nxt;
  logic                 sticky_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;

  // Next-state: buffering, error bookkeeping and RUN/HALT control
  always_comb begin
    state_nxt      = state;
    out_word_nxt   = out_word;
    out_valid_nxt  = out_valid;
    skid_word_nxt  = skid_word;
    skid_valid_nxt = skid_valid;
    sticky_nxt     = sticky_err;
    err_cnt_nxt    = err_cnt;

    // in_ready is low whenever skid is full, so accept and a full skid never coincide
    if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_word_nxt   = skid_word;
        out_valid_nxt  = 1'b1;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        out_word_nxt  = in_word;
        out_valid_nxt = 1'b1;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_word_nxt  = in_word;
      skid_valid_nxt = 1'b1;
    end

    // Clear first so a same-cycle faulty accept still registers afterwards
    if (clr_err) begin
      sticky_nxt  = 1'b0;
      err_cnt_nxt = '0;
      if (state == ST_HALT) begin
        state_nxt = ST_RUN;
      end
    end

    if (accept && in_word.err) begin
      sticky_nxt = 1'b1;
      if (err_cnt_nxt != '1) begin
        err_cnt_nxt = err_cnt_nxt + ERR_CNT_W'(1);
      end
      if (HALT_ON_ERR) begin
        state_nxt = ST_HALT;
      end
    end

    in_ready_nxt = !skid_valid_nxt && (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      out_word   <= '0;
      out_valid  <= 1'b0;
      skid_word  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      sticky_err <= 1'b0;
      err_cnt    <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_word   <= out_word_nxt;
      out_valid  <= out_valid_nxt;
      skid_word  <= skid_word_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= in_ready_nxt;
      sticky_err <= sticky_nxt;
      err_cnt    <= err_cnt_nxt;
      halted     <= (state_nxt == ST_HALT);
    end
  end

  assign out_a   = out_word.nib;
  assign out_err = out_word.err;

endmodule
